// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared FSM state type, counter width and saturating increment
package mult_arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mult_array.sv
// rtl/mult_array.sv - combinational unsigned NxN array multiplier, full 2N-bit product
module mult_array #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   // one shifted partial-product row per multiplier bit, accumulated at full width
   always_comb begin
      p = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) p = p + ({{N{1'b0}}, a} << i);
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, search starts at ptr and wraps
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant
);

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin shared multiplier with one-deep result register
// optional per-requester grant counters under MULT_ARB_STATS_EN
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int NREQ = 2,
   localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0][N-1:0] req_x,
   input  logic [NREQ-1:0][N-1:0] req_y,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [2*N-1:0]         rsp_m,
   output logic [IDW-1:0]         rsp_id
`ifdef MULT_ARB_STATS_EN
   ,
   output logic [NREQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [2*N-1:0]   rsp_m_q, rsp_m_d;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   gnt_idx;
   logic [N-1:0]     sel_x, sel_y;
   logic [2*N-1:0]   prod;
   logic             can_accept;
   logic             xfer;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) gnt_idx = IDW'(i);
      end
      sel_x = req_x[gnt_idx];
      sel_y = req_y[gnt_idx];
   end

   mult_array #(.N(N)) u_mult_array (
      .a (sel_x),
      .b (sel_y),
      .p (prod)
   );

   // the result slot frees up in the same cycle the consumer takes it
   assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
   assign req_ready  = (rst_n && can_accept) ? grant : '0;
   assign xfer       = |req_ready;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      rsp_id_d = rsp_id_q;
      rsp_m_d  = rsp_m_q;
      if (xfer) begin
         state_d  = ST_FULL;
         rsp_m_d  = prod;
         rsp_id_d = gnt_idx;
         rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state_q == ST_FULL && rsp_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         rsp_id_q <= '0;
         rsp_m_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         rsp_id_q <= rsp_id_d;
         rsp_m_q  <= rsp_m_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_m     = rsp_m_q;
   assign rsp_id    = rsp_id_q;

`ifdef MULT_ARB_STATS_EN
   logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i] && req_valid[i]) cnt_d[i] = sat_inc(cnt_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter (N=4, NREQ=2)
module tb_mult_arbiter;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0][3:0] req_x;
   logic [1:0][3:0] req_y;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [7:0]      rsp_m;
   logic            rsp_id;
`ifdef MULT_ARB_STATS_EN
   logic [1:0][15:0] grant_cnt;
`endif

   integer checks = 0;
   integer errors = 0;

   mult_arbiter #(.N(4), .NREQ(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_m     (rsp_m),
      .rsp_id    (rsp_id)
`ifdef MULT_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      req_x = '0;
      req_y = '0;
      step();
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_m !== 8'd0) begin errors++; $display("FAIL reset_m got %0d exp 0", rsp_m); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
      rst_n = 1'b1;
      req_valid = 2'b00;
      step();
   endtask

   task automatic test_single();
      req_valid = 2'b01; req_x[0] = 4'd15; req_y[0] = 4'd15; rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
      step();
      req_valid = 2'b00;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
      checks++; if (rsp_m !== 8'd225) begin errors++; $display("FAIL single_m got %0d exp 225", rsp_m); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %0d exp 0", rsp_id); end
      step();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
   endtask

   task automatic test_operands();
      // pointer now 1 after the req0 grant above
      req_valid = 2'b10; req_x[1] = 4'd0; req_y[1] = 4'd9; rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_ready got %b exp 10", req_ready); end
      step();
      req_valid = 2'b01; req_x[0] = 4'd1; req_y[0] = 4'd13;
      #1;
      checks++; if (rsp_m !== 8'd0 || rsp_id !== 1'b1) begin errors++; $display("FAIL zero_m got %0d/%0d exp 0/1", rsp_m, rsp_id); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL one_ready got %b exp 01", req_ready); end
      step();
      req_valid = 2'b00;
      #1;
      checks++; if (rsp_m !== 8'd13 || rsp_id !== 1'b0) begin errors++; $display("FAIL one_m got %0d/%0d exp 13/0", rsp_m, rsp_id); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_rdy;
      logic [7:0] exp_m;
      do_reset();
      req_x[0] = 4'd3; req_y[0] = 4'd5; req_x[1] = 4'd7; req_y[1] = 4'd6;
      req_valid = 2'b11; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_m   = (k % 2 == 0) ? 8'd15 : 8'd42;
         #1;
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
         step();
         checks++; if (rsp_valid !== 1'b1 || rsp_m !== exp_m || rsp_id !== 1'(k % 2)) begin
            errors++; $display("FAIL b2b_rsp[%0d] got v%b m%0d id%0d exp v1 m%0d id%0d", k, rsp_valid, rsp_m, rsp_id, exp_m, k % 2);
         end
      end
      req_valid = 2'b00;
      step();
   endtask

   task automatic test_stall();
      req_valid = 2'b11; rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_empty_ready got %b exp 01", req_ready); end
      step();
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 00", k, req_ready); end
         checks++; if (rsp_valid !== 1'b1 || rsp_m !== 8'd15 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] got v%b m%0d id%0d exp v1 m15 id0", k, rsp_valid, rsp_m, rsp_id);
         end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release_ready got %b exp 10", req_ready); end
      step();
      req_valid = 2'b00;
      #1;
      checks++; if (rsp_m !== 8'd42 || rsp_id !== 1'b1) begin errors++; $display("FAIL stall_next got %0d/%0d exp 42/1", rsp_m, rsp_id); end
      step();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", rsp_valid); end
   endtask

   task automatic test_reset_mid();
      req_x[0] = 4'd2; req_y[0] = 4'd2;
      req_valid = 2'b01; rsp_ready = 1'b0;
      step();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_m !== 8'd4) begin errors++; $display("FAIL mid_held got v%b m%0d exp v1 m4", rsp_valid, rsp_m); end
      rst_n = 1'b0; req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_rst_ready got %b exp 00", req_ready); end
      step();
      rst_n = 1'b1;
      req_x[0] = 4'd3; req_y[0] = 4'd5;
      #1;
      checks++; if (rsp_valid !== 1'b0 || rsp_m !== 8'd0) begin errors++; $display("FAIL mid_discard got v%b m%0d exp v0 m0", rsp_valid, rsp_m); end
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr_ready got %b exp 01", req_ready); end
      step();
      req_valid = 2'b00; rsp_ready = 1'b1;
      #1;
      checks++; if (rsp_m !== 8'd15 || rsp_id !== 1'b0) begin errors++; $display("FAIL mid_after got %0d/%0d exp 15/0", rsp_m, rsp_id); end
      step();
   endtask

`ifdef MULT_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      #1;
      checks++; if (grant_cnt[0] !== 16'd0 || grant_cnt[1] !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", grant_cnt[0], grant_cnt[1]); end
      req_valid = 2'b10; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stats_ready[%0d] got %b exp 10", k, req_ready); end
         step();
      end
      req_valid = 2'b00;
      #1;
      checks++; if (grant_cnt[1] !== 16'd5) begin errors++; $display("FAIL stats_cnt1 got %0d exp 5", grant_cnt[1]); end
      checks++; if (grant_cnt[0] !== 16'd0) begin errors++; $display("FAIL stats_cnt0 got %0d exp 0", grant_cnt[0]); end
      step();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      req_x = '0;
      req_y = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_operands();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef MULT_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits, N >= 2.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters, NREQ >= 2.
REQ-003 SHALL have these ports, clock and reset first:
  clk  input  1  single clock; all state updates on its rising edge.
  rst_n  input  1  reset, synchronous, active-low.
  req_valid  input  [NREQ]  per-requester operand-pair valid.
  req_ready  output  [NREQ]  per-requester accept strobe.
  req_x  input  [NREQ][N]  per-requester multiplicand, unsigned.
  req_y  input  [NREQ][N]  per-requester multiplier, unsigned.
  rsp_valid  output  1  result valid.
  rsp_ready  input  1  consumer accepts result.
  rsp_m  output  2N  product, unsigned.
  rsp_id  output  max(1,$clog2(NREQ))  index of the requester that owns rsp_m.
  grant_cnt  output  [NREQ][16]  per-requester grant counters; present only with MULT_ARB_STATS_EN.

Function
REQ-004 SHALL share one instance of the combinational N-bit array multiplier between all requesters.
REQ-005 SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-006 SHALL be able to accept a request ("can_accept") when state is EMPTY, or when state is FULL and rsp_ready=1 in the same cycle.
REQ-007 SHALL grant at most one requester per cycle: the first i with req_valid[i]=1, searching round-robin from rr_ptr upward modulo NREQ.
REQ-008 SHALL drive req_ready[i]=1 only when can_accept=1 and i is the granted index; req_ready SHALL be all zero otherwise.
REQ-009 SHALL treat a transfer as req_valid[i] & req_ready[i]; on a transfer, rsp_m SHALL load req_x[i]*req_y[i], rsp_id SHALL load i, and the state SHALL become FULL.
REQ-010 SHALL set rr_ptr to (granted index + 1) mod NREQ on each transfer, and leave it unchanged otherwise.
REQ-011 SHALL present the result one cycle after the transfer: rsp_valid rises on the edge after req_ready was sampled high.
REQ-012 SHALL hold rsp_valid, rsp_m and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-013 SHALL go from FULL to EMPTY when rsp_ready=1 and there is no transfer in the same cycle.
REQ-014 SHALL handle rsp_ready=1 together with a new transfer in FULL by staying FULL and loading the new result, sustaining one result per cycle.
REQ-015 SHALL make req_ready and the grant independent of rsp_ready when the state is EMPTY.
REQ-016 SHALL compute products exactly to the full 2N-bit width; max operands give (2^N-1)^2 with no truncation.

Reset
REQ-017 SHALL, while rst_n=0 at a clock edge, set the state to EMPTY, rr_ptr=0, rsp_valid=0, rsp_m=0, rsp_id=0, and grant_cnt=0 when present.
REQ-018 SHALL drive req_ready all zero during any cycle in which rst_n=0.
REQ-019 SHALL, when reset is asserted mid-operation, discard a held result without delivering it.

Configuration
REQ-020 SHALL, when macro MULT_ARB_STATS_EN is defined, provide grant_cnt: each counter increments on its requester's transfer and saturates at 16'hFFFF.
REQ-021 SHALL, when MULT_ARB_STATS_EN is undefined, have no grant_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-022 SHALL place the FSM state enum (EMPTY, FULL) and the counter-width constant (16) in shared package mult_arb_pkg.
REQ-023 SHALL use one sub-module, rr_arbiter (inputs: request vector, pointer; output: one-hot grant), plus the array multiplier instance.

Verification
REQ-024 Bench SHALL cover: N=4, req0 only, x=15, y=15, rsp_ready=1 -> rsp_valid next cycle, rsp_m=225, rsp_id=0.
REQ-025 Bench SHALL cover: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle.
REQ-026 Bench SHALL cover: rsp_ready=0 for 3 cycles while FULL -> req_ready=0, and rsp_m and rsp_id held stable; rsp_ready=1 -> next grant in that same cycle.
REQ-027 Bench SHALL cover: x=0, y=9 -> rsp_m=0; x=1, y=13 -> rsp_m=13.
REQ-028 Bench SHALL cover: rst_n=0 while FULL -> next cycle rsp_valid=0 and rr_ptr=0; the held result is never delivered.
REQ-029 Bench SHALL cover, with MULT_ARB_STATS_EN defined: 5 grants to req1 -> grant_cnt[1]=5 and grant_cnt[0]=0.
